// File: rtl/dual_port_ram_be.sv
// Simple dual-port RAM: one write port (A) and one read port (B) on a single
// clock. Writes honour per-byte enables. Reads have a 1- or 2-stage pipeline
// with a valid strobe. Same-address read/write collisions return either the
// freshly written bytes merged over the old word, or the old word unchanged.
// An optional sequencer zeroes every word after reset, before traffic is taken.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | writing zero to mem[clr_cnt]; port traffic ignored, init_busy=1
// ST_READY | normal read/write operation until the next reset
module dual_port_ram_be #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 8,
   parameter int READ_LATENCY   = 1,
   parameter int BYPASS         = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic                    rd_en,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_valid,
   output logic                    init_busy
);

   localparam int DEPTH     = 1 << ADDR_WIDTH;
   localparam int NUM_BYTES = DATA_WIDTH / 8;

   if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
      $error("dual_port_ram_be: DATA_WIDTH must be a multiple of 8");
   end
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_read_latency
      $error("dual_port_ram_be: READ_LATENCY must be 1 or 2");
   end

   typedef enum logic {
      ST_CLEAR,
      ST_READY
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   clr_cnt;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [DATA_WIDTH-1:0]   wr_mask;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic                    ready;
   logic                    collide;
   logic [DATA_WIDTH-1:0]   s1_data;
   logic                    s1_valid;

   assign ready   = (state == ST_READY);
   assign collide = wr_en && (wr_addr == rd_addr);

   // Expand byte enables into a bit mask over the data word.
   always_comb begin
      wr_mask = '0;
      for (int i = 0; i < NUM_BYTES; i++) begin
         wr_mask[8*i +: 8] = {8{wr_be[i]}};
      end
   end

   // Word seen by the read port; in write-first mode the enabled bytes of a
   // same-address write are forwarded over the stored word.
   always_comb begin
      rd_word = mem[rd_addr];
      if (BYPASS != 0 && collide) begin
         rd_word = (mem[rd_addr] & ~wr_mask) | (wr_data & wr_mask);
      end
   end

   // Clear sequencer: walks every address once after reset, then idles in READY.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         clr_cnt   <= '0;
         init_busy <= (CLEAR_ON_RESET != 0);
      end else begin
         case (state)
            ST_CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                  state     <= ST_READY;
                  init_busy <= 1'b0;
               end
            end
            default: begin
               state <= ST_READY;
            end
         endcase
      end
   end

   // Storage: clear writes take priority; user writes only merge enabled lanes.
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR) begin
         mem[clr_cnt] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
      end
   end

   // First read stage: capture the addressed word when a read is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_data  <= '0;
         s1_valid <= 1'b0;
      end else if (ready && rd_en) begin
         s1_data  <= rd_word;
         s1_valid <= 1'b1;
      end else begin
         s1_valid <= 1'b0;
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      // Second read stage: data only moves when a result arrives, so it holds.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
         end else begin
            rd_valid <= s1_valid;
            if (s1_valid) begin
               rd_data <= s1_data;
            end
         end
      end
   end else begin : g_lat1
      assign rd_data  = s1_data;
      assign rd_valid = s1_valid;
   end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be. Two instances share all stimulus:
//   dut_a: READ_LATENCY=1, BYPASS=1 (write-first)
//   dut_b: READ_LATENCY=2, BYPASS=0 (read-first)
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_dual_port_ram_be;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_be = '0;
   logic        rd_en = 1'b0;
   logic [3:0]  rd_addr = '0;

   logic [31:0] rd_data_a, rd_data_b;
   logic        rd_valid_a, rd_valid_b;
   logic        init_busy_a, init_busy_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dual_port_ram_be #(
      .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .BYPASS(1), .CLEAR_ON_RESET(1)
   ) dut_a (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
      .rd_valid(rd_valid_a), .init_busy(init_busy_a)
   );

   dual_port_ram_be #(
      .DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .BYPASS(0), .CLEAR_ON_RESET(1)
   ) dut_b (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .rd_valid(rd_valid_b), .init_busy(init_busy_b)
   );

   typedef struct {
      logic        wr_en;
      logic [3:0]  wr_addr;
      logic [31:0] wr_data;
      logic [3:0]  wr_be;
      logic        rd_en;
      logic [3:0]  rd_addr;
      logic [31:0] exp_a;   // expected read result, write-first instance
      logic [31:0] exp_b;   // expected read result, read-first instance
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                               input logic [3:0] be, input logic re, input logic [3:0] ra,
                               input logic [31:0] ea, input logic [31:0] eb);
      vec_t v;
      v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.wr_be = be;
      v.rd_en = re; v.rd_addr = ra; v.exp_a = ea; v.exp_b = eb;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      wr_en = 1'b0; wr_be = '0; wr_addr = '0; wr_data = '0;
      rd_en = 1'b0; rd_addr = '0;
   endtask

   // Apply vecs[first..last] one per cycle; dut_a answers one cycle later,
   // dut_b two cycles later.
   task automatic run_vecs(input int first, input int last);
      for (int k = first; k <= last + 1; k++) begin
         if (k <= last) begin
            wr_en = vecs[k].wr_en; wr_addr = vecs[k].wr_addr; wr_data = vecs[k].wr_data;
            wr_be = vecs[k].wr_be; rd_en = vecs[k].rd_en; rd_addr = vecs[k].rd_addr;
         end else begin
            idle();
         end
         @(negedge clk);
         if (k <= last) begin
            check($sformatf("vec%0d a rd_valid", k), {31'b0, rd_valid_a}, {31'b0, vecs[k].rd_en});
            if (vecs[k].rd_en) check($sformatf("vec%0d a rd_data", k), rd_data_a, vecs[k].exp_a);
         end else begin
            check("tail a rd_valid", {31'b0, rd_valid_a}, 32'd0);
         end
         if (k > first) begin
            check($sformatf("vec%0d b rd_valid", k - 1), {31'b0, rd_valid_b}, {31'b0, vecs[k-1].rd_en});
            if (vecs[k-1].rd_en) check($sformatf("vec%0d b rd_data", k - 1), rd_data_b, vecs[k-1].exp_b);
         end else begin
            check("head b rd_valid", {31'b0, rd_valid_b}, 32'd0);
         end
      end
   endtask

   // Release reset on a falling edge and count cycles with init_busy high,
   // while leaving port traffic driven; no read may complete meanwhile.
   task automatic release_and_count(input string tag);
      int cnt = 0;
      logic saw_valid = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (rd_valid_a || rd_valid_b) saw_valid = 1'b1;
         if (!init_busy_a) break;
         cnt++;
         @(negedge clk);
      end
      idle();
      check({tag, " busy cycles"}, cnt, 32'd16);
      check({tag, " busy b"}, {31'b0, init_busy_b}, 32'd0);
      @(negedge clk);
      if (rd_valid_a || rd_valid_b) saw_valid = 1'b1;
      check({tag, " rd_valid during clear"}, {31'b0, saw_valid}, 32'd0);
   endtask

   initial begin
      // Reads of all addresses after the clear (vectors 0..15).
      for (int a = 0; a < 16; a++) vecs.push_back(mk(0, 0, 0, 0, 1, 4'(a), 0, 0));
      // Functional vectors (16..34).
      vecs.push_back(mk(1, 3, 32'hAABBCCDD, 4'b1111, 0, 0, 0, 0));
      vecs.push_back(mk(1, 3, 32'h11223344, 4'b0101, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 3, 32'hAA22CC44, 32'hAA22CC44));
      vecs.push_back(mk(1, 5, 32'h12345678, 4'b1111, 0, 0, 0, 0));
      vecs.push_back(mk(1, 5, 32'hFFFFFFFF, 4'b0011, 1, 5, 32'h1234FFFF, 32'h12345678));
      vecs.push_back(mk(0, 0, 0, 0, 1, 5, 32'h1234FFFF, 32'h1234FFFF));
      vecs.push_back(mk(1, 0, 32'h0, 4'b1111, 1, 3, 32'hAA22CC44, 32'hAA22CC44));
      vecs.push_back(mk(1, 1, 32'h1, 4'b1111, 0, 0, 0, 0));
      vecs.push_back(mk(1, 2, 32'h2, 4'b1111, 0, 0, 0, 0));
      vecs.push_back(mk(1, 3, 32'h3, 4'b1111, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0, 32'h0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h1, 32'h1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 2, 32'h2, 32'h2));
      vecs.push_back(mk(0, 0, 0, 0, 1, 3, 32'h3, 32'h3));
      vecs.push_back(mk(1, 2, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 2, 32'h2, 32'h2));
      vecs.push_back(mk(1, 9, 32'hA5FFFFFF, 4'b1000, 0, 0, 0, 0));
      vecs.push_back(mk(1, 9, 32'hFFFFFFFF, 4'b0000, 1, 9, 32'hA5000000, 32'hA5000000));
      vecs.push_back(mk(1, 14, 32'h0000BEEF, 4'b0001, 1, 15, 32'h0, 32'h0));
      // Post mid-operation reset reads (35..36).
      vecs.push_back(mk(0, 0, 0, 0, 1, 3, 32'h0, 32'h0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 9, 32'h0, 32'h0));

      // Reset state.
      #1 rst = 1'b1;
      #1;
      check("reset a rd_data", rd_data_a, 32'd0);
      check("reset a rd_valid", {31'b0, rd_valid_a}, 32'd0);
      check("reset a init_busy", {31'b0, init_busy_a}, 32'd1);
      check("reset b rd_data", rd_data_b, 32'd0);
      check("reset b rd_valid", {31'b0, rd_valid_b}, 32'd0);
      check("reset b init_busy", {31'b0, init_busy_b}, 32'd1);

      // Traffic during clear must be ignored.
      @(negedge clk);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hDEADBEEF; wr_be = 4'b1111;
      rd_en = 1'b1; rd_addr = 4'd7;
      release_and_count("clear1");

      run_vecs(0, 15);
      run_vecs(16, 34);

      // Mid-operation reset while a read is in flight.
      rd_en = 1'b1; rd_addr = 4'd3;
      @(negedge clk);
      idle();
      check("pre-rst a rd_valid", {31'b0, rd_valid_a}, 32'd1);
      check("pre-rst a rd_data", rd_data_a, 32'h3);
      #2 rst = 1'b1;
      #1;
      check("mid-rst a rd_valid", {31'b0, rd_valid_a}, 32'd0);
      check("mid-rst a rd_data", rd_data_a, 32'd0);
      check("mid-rst b rd_valid", {31'b0, rd_valid_b}, 32'd0);
      check("mid-rst b rd_data", rd_data_b, 32'd0);
      check("mid-rst init_busy", {31'b0, init_busy_b}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      release_and_count("clear2");
      run_vecs(35, 36);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
